mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter and a single-port memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic          m0_lock;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_wd;
    logic          m0_ack;
    logic [DW-1:0] m0_rd;

    logic          m1_req;
    logic          m1_we;
    logic          m1_lock;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_wd;
    logic          m1_ack;
    logic [DW-1:0] m1_rd;

    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic [1:0]    owner;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_adr, m0_wd,
        output m0_ack, m0_rd,
        input  m1_req, m1_we, m1_lock, m1_adr, m1_wd,
        output m1_ack, m1_rd,
        output mem_we, mem_adr, mem_wd, owner,
        input  mem_rd
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_adr, m0_wd,
        input  m0_ack, m0_rd,
        output m1_req, m1_we, m1_lock, m1_adr, m1_wd,
        input  m1_ack, m1_rd,
        input  mem_we, mem_adr, mem_wd, owner,
        output mem_rd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: one IDLE arbitration cycle plus one SERVE access
// cycle per transfer, round-robin on ties, lock bursts capped at MAX_BURST.
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t        state;
    logic [1:0]    owner_q;
    logic [BW-1:0] burst_cnt;
    logic          lock_active;
    logic          last_m1;

    logic [1:0]    rr_grant;
    logic          locked_req;
    logic          owner_lock;
    logic          serve;
    logic          sel_we;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_wd;

    assign serve      = (state == SERVE);
    assign locked_req = last_m1 ? bus.m1_req : bus.m0_req;
    assign owner_lock = (owner_q[0] & bus.m0_lock) | (owner_q[1] & bus.m1_lock);

    // On a tie the master that was not served last wins.
    always_comb begin
        rr_grant = 2'b00;
        if (bus.m0_req && bus.m1_req)
            rr_grant = last_m1 ? 2'b01 : 2'b10;
        else if (bus.m0_req)
            rr_grant = 2'b01;
        else if (bus.m1_req)
            rr_grant = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner_q     <= 2'b00;
            burst_cnt   <= '0;
            lock_active <= 1'b0;
            last_m1     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (lock_active && locked_req) begin
                        owner_q <= last_m1 ? 2'b10 : 2'b01;
                        state   <= SERVE;
                    end else begin
                        // Lock (if any) is forfeited once the holder skips this slot.
                        lock_active <= 1'b0;
                        burst_cnt   <= '0;
                        if (rr_grant != 2'b00) begin
                            owner_q <= rr_grant;
                            state   <= SERVE;
                        end
                    end
                end
                SERVE: begin
                    state   <= IDLE;
                    owner_q <= 2'b00;
                    last_m1 <= owner_q[1];
                    if (owner_lock && (int'(burst_cnt) < MAX_BURST - 1)) begin
                        lock_active <= 1'b1;
                        burst_cnt   <= burst_cnt + 1'b1;
                    end else begin
                        lock_active <= 1'b0;
                        burst_cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port follows the owner's live request fields during SERVE only.
    always_comb begin
        sel_we    = 1'b0;
        sel_adr   = '0;
        sel_wd    = '0;
        bus.m0_rd = '0;
        bus.m1_rd = '0;
        if (serve && owner_q[0]) begin
            sel_we    = bus.m0_we;
            sel_adr   = bus.m0_adr;
            sel_wd    = bus.m0_wd;
            bus.m0_rd = bus.mem_rd;
        end else if (serve && owner_q[1]) begin
            sel_we    = bus.m1_we;
            sel_adr   = bus.m1_adr;
            sel_wd    = bus.m1_wd;
            bus.m1_rd = bus.mem_rd;
        end
    end

    assign bus.mem_we  = sel_we;
    assign bus.mem_adr = sel_adr;
    assign bus.mem_wd  = sel_wd;
    assign bus.owner   = owner_q;
    assign bus.m0_ack  = serve & owner_q[0];
    assign bus.m1_ack  = serve & owner_q[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-master drivers, a transaction-level grant model
// feeding a scoreboard, and a monitor that checks every ack against it.
module tb_mem_arbiter;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
    localparam int WAIT_MAX  = (MAX_BURST + 1) * 2;

    typedef struct {
        int            m;
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        longint        due;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          req  [2];
    logic          we   [2];
    logic          lock [2];
    logic [AW-1:0] adr  [2];
    logic [DW-1:0] wd   [2];
    logic [DW-1:0] mem_arr [64];

    exp_t   sb[$];
    int     ack_log[$];
    longint cyc    = 0;
    int     checks = 0;
    int     passes = 0;
    bit     mon_en = 0;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.m0_req  = req[0];
    assign bus.m0_we   = we[0];
    assign bus.m0_lock = lock[0];
    assign bus.m0_adr  = adr[0];
    assign bus.m0_wd   = wd[0];
    assign bus.m1_req  = req[1];
    assign bus.m1_we   = we[1];
    assign bus.m1_lock = lock[1];
    assign bus.m1_adr  = adr[1];
    assign bus.m1_wd   = wd[1];
    assign bus.mem_rd  = mem_arr[bus.mem_adr[7:2]];

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: combinational read, write on the rising edge.
    initial begin
        for (int i = 0; i < 64; i++) mem_arr[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus.mem_we) mem_arr[bus.mem_adr[7:2]] = bus.mem_wd;
        end
    end

    // Reference model: decides each grant from the visible requests and the
    // history of served accesses, then predicts ack cycle and data.
    initial begin : model
        logic [DW-1:0] ref_mem [64];
        exp_t e;
        int   last      = 1;
        int   run       = 0;
        int   cur       = 0;
        int   grant;
        bit   busy      = 0;
        bit   lock_pend = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0; last = 1; run = 0; lock_pend = 0;
            end else if (busy) begin
                busy      = 0;
                lock_pend = lock[cur] && (run < MAX_BURST);
            end else begin
                grant = -1;
                if (lock_pend && req[last]) begin
                    grant = last;
                    run++;
                end else begin
                    if (req[0] && req[1]) grant = 1 - last;
                    else if (req[0])      grant = 0;
                    else if (req[1])      grant = 1;
                    run = 1;
                end
                lock_pend = 0;
                if (grant >= 0) begin
                    e.m   = grant;
                    e.we  = we[grant];
                    e.adr = adr[grant];
                    e.wd  = wd[grant];
                    e.rd  = ref_mem[adr[grant][7:2]];
                    e.due = cyc + 1;
                    if (we[grant]) ref_mem[adr[grant][7:2]] = wd[grant];
                    sb.push_back(e);
                    last = grant;
                    cur  = grant;
                    busy = 1;
                end
            end
        end
    end

    initial begin : monitor
        exp_t       e;
        logic [1:0] acks;
        logic [1:0] exp_acks;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                acks = {bus.m1_ack, bus.m0_ack};
                if (acks != 2'b00) begin
                    ack_log.push_back(acks[1] ? 1 : 0);
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_ack", longint'(acks), 0);
                    end else begin
                        e = sb.pop_front();
                        exp_acks = (e.m == 1) ? 2'b10 : 2'b01;
                        chk(acks == exp_acks, "ack_master", longint'(acks), longint'(exp_acks));
                        chk(cyc == e.due, "ack_cycle", cyc, e.due);
                        chk(bus.owner == exp_acks, "owner", longint'(bus.owner), longint'(exp_acks));
                        chk(bus.mem_we == e.we, "mem_we", longint'(bus.mem_we), longint'(e.we));
                        chk(bus.mem_adr == e.adr, "mem_adr", longint'(bus.mem_adr), longint'(e.adr));
                        if (e.we)
                            chk(bus.mem_wd == e.wd, "mem_wd", longint'(bus.mem_wd), longint'(e.wd));
                        else if (e.m == 0)
                            chk(bus.m0_rd == e.rd, "m0_rd", longint'(bus.m0_rd), longint'(e.rd));
                        else
                            chk(bus.m1_rd == e.rd, "m1_rd", longint'(bus.m1_rd), longint'(e.rd));
                        if (e.m == 0)
                            chk(bus.m1_rd == '0, "m1_rd_idle", longint'(bus.m1_rd), 0);
                        else
                            chk(bus.m0_rd == '0, "m0_rd_idle", longint'(bus.m0_rd), 0);
                    end
                end else if (sb.size() > 0 && sb[0].due < cyc) begin
                    chk(1'b0, "missing_ack", 0, sb[0].due);
                    e = sb.pop_front();
                end
            end
        end
    end

    task automatic issue(input int m, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic l);
        we[m]   = w;
        adr[m]  = a;
        wd[m]   = d;
        lock[m] = l;
        req[m]  = 1'b1;
    endtask

    task automatic finish_txn(input int m, output logic [DW-1:0] rd);
        int   t   = 0;
        logic got = 1'b0;
        rd = '0;
        while (!got && t < 40) begin
            @(negedge clk);
            t++;
            got = (m == 0) ? bus.m0_ack : bus.m1_ack;
            rd  = (m == 0) ? bus.m0_rd : bus.m1_rd;
        end
        chk(got && (t <= WAIT_MAX), $sformatf("wait_m%0d", m), longint'(t), longint'(WAIT_MAX));
        @(posedge clk);
        #1;
        req[m]  = 1'b0;
        lock[m] = 1'b0;
    endtask

    task automatic drive(input int m, input int n, input int max_gap,
                         input int we_mode, input int lock_mode);
        logic [DW-1:0] rd;
        logic          w;
        logic          l;
        for (int k = 0; k < n; k++) begin
            int gap = $urandom_range(max_gap, 0);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            w = (we_mode == 2) ? 1'($urandom_range(1, 0)) : (we_mode == 1);
            l = (lock_mode == 2) ? 1'($urandom_range(1, 0)) : (lock_mode == 1);
            issue(m, w, {24'h0, 6'($urandom_range(63, 0)), 2'b00}, $urandom, l);
            finish_txn(m, rd);
        end
    endtask

    task automatic check_order(input logic [15:0] seq, input int n, input string name);
        chk(ack_log.size() == n, {name, "_len"}, longint'(ack_log.size()), longint'(n));
        for (int i = 0; i < n && i < ack_log.size(); i++)
            chk(ack_log[i] == int'(seq[i]), $sformatf("%s_%0d", name, i),
                longint'(ack_log[i]), longint'(seq[i]));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; we[m] = 1'b0; lock[m] = 1'b0; adr[m] = '0; wd[m] = '0;
        end
        // Both masters already requesting while reset is held.
        issue(0, 1'b1, 32'h80, 32'hA0A0_A0A0, 1'b0);
        issue(1, 1'b1, 32'h84, 32'hB1B1_B1B1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk(bus.owner == 2'b00, "rst_owner", longint'(bus.owner), 0);
            chk({bus.m1_ack, bus.m0_ack} == 2'b00, "rst_ack", longint'({bus.m1_ack, bus.m0_ack}), 0);
            chk(bus.mem_we == 1'b0, "rst_mem_we", longint'(bus.mem_we), 0);
            chk(bus.mem_adr == '0, "rst_mem_adr", longint'(bus.mem_adr), 0);
            chk(bus.mem_wd == '0, "rst_mem_wd", longint'(bus.mem_wd), 0);
        end
        mon_en = 1;
        ack_log.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Tie out of reset: m0 first, then m1.
        fork
            finish_txn(0, rd0);
            finish_txn(1, rd1);
        join
        check_order(16'h0002, 2, "order_tie");

        issue(0, 1'b0, 32'h10, '0, 1'b0);
        finish_txn(0, rd0);
        chk(rd0 == 32'hDEAD_BEEF, "rd_preload", longint'(rd0), 32'hDEAD_BEEF);

        issue(0, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
        finish_txn(0, rd0);
        issue(1, 1'b0, 32'h20, '0, 1'b0);
        finish_txn(1, rd1);
        chk(rd1 == 32'h1234_5678, "rd_after_wr", longint'(rd1), 32'h1234_5678);

        repeat (10) begin
            @(negedge clk);
            chk(bus.mem_we == 1'b0, "idle_mem_we", longint'(bus.mem_we), 0);
            chk(bus.owner == 2'b00, "idle_owner", longint'(bus.owner), 0);
            chk({bus.m1_ack, bus.m0_ack} == 2'b00, "idle_ack", longint'({bus.m1_ack, bus.m0_ack}), 0);
        end

        // m1 locked burst of 6 writes against continuous m0 reads.
        @(posedge clk);
        #1;
        ack_log.delete();
        fork
            drive(0, 3, 0, 0, 0);
            drive(1, 6, 0, 1, 1);
        join
        check_order(16'h00DE, 9, "order_lock");

        // Reset lands on the edge that ends an m1 write.
        issue(1, 1'b1, 32'h40, 32'hCAFE_F00D, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        req[1] = 1'b0;
        @(negedge clk);
        chk(bus.owner == 2'b00, "rst_serve_owner", longint'(bus.owner), 0);
        chk(bus.m1_ack == 1'b0, "rst_serve_ack", longint'(bus.m1_ack), 0);
        chk(bus.mem_we == 1'b0, "rst_serve_mem_we", longint'(bus.mem_we), 0);
        chk(mem_arr[16] == 32'hCAFE_F00D, "rst_serve_commit", longint'(mem_arr[16]), 32'hCAFE_F00D);

        @(posedge clk);
        #1;
        fork
            drive(0, 40, 3, 2, 2);
            drive(1, 40, 3, 2, 2);
        join

        repeat (4) @(negedge clk);
        chk(sb.size() == 0, "sb_drain", longint'(sb.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
